// File: rtl/fir_pkg.sv
// Shared definitions for the serial 128-tap FIR filter.
//   fir_state_t  : control FSM states of top_level
//   DEF_*        : default sample width and tap count
//   ACC_WIDTH    : accumulator width (full product plus log2 of the tap count)
//   FIR_COEFFS   : fixed Q1.23 coefficient set (symmetric triangular low-pass)
//   sat_q23()    : rescales the accumulator by 2^-23 and clamps it to the sample range
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_FIR_DEPTH  = 128;
  localparam int PTR_W          = $clog2(DEF_FIR_DEPTH);
  localparam int ACC_WIDTH      = 2 * DEF_DATA_WIDTH + PTR_W;

  // The taps rise linearly to the centre and fall back again. The step is chosen
  // so that the DC gain is just above 2.0 (sum of taps = 4160 * 4034).
  localparam int unsigned COEFF_STEP = 4034;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX,
    ST_MAC,
    ST_OUT_WAIT,
    ST_TX
  } fir_state_t;

  typedef logic signed [DEF_DATA_WIDTH-1:0] coeff_t;
  typedef coeff_t [DEF_FIR_DEPTH-1:0]       coeff_arr_t;

  function automatic coeff_arr_t gen_coeffs();
    coeff_arr_t  c;
    int unsigned tap;
    c = '0;
    for (int unsigned k = 0; k < DEF_FIR_DEPTH; k++) begin
      tap = (k < DEF_FIR_DEPTH / 2) ? k + 1 : DEF_FIR_DEPTH - k;
      c[PTR_W'(k)] = coeff_t'(tap * COEFF_STEP);
    end
    return c;
  endfunction

  localparam coeff_arr_t FIR_COEFFS = gen_coeffs();

  // The result is in range when every bit from the sign down to bit 23 of the
  // shifted value agrees; otherwise it clamps towards the sign.
  function automatic logic [DEF_DATA_WIDTH-1:0] sat_q23(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = acc >>> (DEF_DATA_WIDTH - 1);
    if (!sh[ACC_WIDTH-1] && (|sh[ACC_WIDTH-2:DEF_DATA_WIDTH-1]))
      return {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    if (sh[ACC_WIDTH-1] && !(&sh[ACC_WIDTH-2:DEF_DATA_WIDTH-1]))
      return {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};
    return sh[DEF_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_if.sv
// Serial sample link of the FIR filter, named from the filter's point of view.
//   i_din, i_din_valid : LSB-first input bit stream and its valid (source -> filter)
//   o_ready            : filter can accept a new input word (filter -> source)
//   o_dout, o_dout_valid : LSB-first output bit stream and word-available flag (filter -> sink)
//   i_ready            : sink ready to take the output word (sink -> filter)
// slave is the filter side, master the source/sink side.
interface fir_if;
  logic i_din;
  logic i_din_valid;
  logic i_ready;
  logic o_ready;
  logic o_dout;
  logic o_dout_valid;

  modport slave (
    input  i_din, i_din_valid, i_ready,
    output o_ready, o_dout, o_dout_valid
  );

  modport master (
    output i_din, i_din_valid, i_ready,
    input  o_ready, o_dout, o_dout_valid
  );
endinterface

// File: rtl/fir_mac.sv
// Delay line, coefficient ROM and single multiply-accumulate of the FIR filter.
//   i_clk, i_rst, i_en : clock, synchronous active-high reset, clock enable
//   i_start            : write i_sample at the head of the delay line and start a pass
//   i_sample           : newest input sample
//   o_done             : one-cycle pulse, o_result valid from this cycle on
//   o_result           : saturated Q1.23-scaled filter output
// i_start at edge E0 -> taps accumulated on E1..E_DEPTH -> result registered and
// o_done raised on E_DEPTH+1.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIR_DEPTH  = DEF_FIR_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int AW = $clog2(FIR_DEPTH);

  logic signed [DATA_WIDTH-1:0]   r_line [FIR_DEPTH];
  logic        [AW-1:0]           r_head;
  logic        [AW-1:0]           r_k;
  logic                           r_busy;
  logic                           r_last;
  logic                           r_done;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic        [DATA_WIDTH-1:0]   r_result;

  logic        [AW-1:0]           w_rd_idx;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;

  // r_head already points past the newest sample, so tap k sits k+1 slots behind it.
  assign w_rd_idx   = r_head - AW'(1) - r_k;
  assign w_prod     = r_line[w_rd_idx] * $signed(FIR_COEFFS[r_k]);
  assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < FIR_DEPTH; i++) r_line[AW'(i)] <= '0;
      r_head   <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (i_en) begin
      r_done <= 1'b0;
      r_last <= 1'b0;
      if (i_start) begin
        r_line[r_head] <= i_sample;
        r_head         <= r_head + AW'(1);
        r_acc          <= '0;
        r_k            <= '0;
        r_busy         <= 1'b1;
      end else if (r_busy) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + AW'(1);
        if (r_k == '1) begin
          r_busy <= 1'b0;
          r_last <= 1'b1;
        end
      end else if (r_last) begin
        r_result <= sat_q23(r_acc);
        r_done   <= 1'b1;
      end
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: rtl/top_level.sv
// Serial-in/serial-out 128-tap FIR filter for 24-bit signed samples.
//   i_clk : clock, all logic on the rising edge
//   i_rst : synchronous active-high reset
//   i_en  : clock enable, low freezes all state and outputs
//   io    : serial sample link (fir_if.slave): input word in under i_din_valid/o_ready,
//           filtered word out under o_dout_valid/i_ready, both LSB first
// One sample is in flight at a time; o_ready stays low from the first received bit
// until the filtered word has been shifted out.
module top_level
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIR_DEPTH  = DEF_FIR_DEPTH
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  fir_if.slave io
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(DATA_WIDTH - 2);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_WIDTH - 1);

  fir_state_t            r_state, w_state_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_dout, w_dout_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rx, w_rx_nxt;
  logic [DATA_WIDTH-1:0] r_tx, w_tx_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;

  logic                  w_start;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_result;

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIR_DEPTH  (FIR_DEPTH)
  ) u_mac (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_en),
    .i_start  (w_start),
    .i_sample (w_rx_nxt),
    .o_done   (w_done),
    .o_result (w_result)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid;
    w_rx_nxt    = r_rx;
    w_tx_nxt    = r_tx;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (io.i_din_valid && r_ready) begin
          w_rx_nxt    = {io.i_din, r_rx[DATA_WIDTH-1:1]};
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RX;
        end
      end
      ST_RX: begin
        // Bits enter at the top, so after 24 shifts bit 0 lands at the LSB.
        w_rx_nxt = {io.i_din, r_rx[DATA_WIDTH-1:1]};
        if (r_cnt == RX_LAST) begin
          w_start     = 1'b1;
          w_state_nxt = ST_MAC;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_MAC: begin
        if (w_done) begin
          w_tx_nxt    = w_result;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OUT_WAIT;
        end
      end
      ST_OUT_WAIT: begin
        if (io.i_ready) begin
          w_dout_nxt  = r_tx[0];
          w_tx_nxt    = r_tx >> 1;
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_TX;
        end
      end
      ST_TX: begin
        if (r_cnt == TX_LAST) begin
          w_dout_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_dout_nxt = r_tx[0];
          w_tx_nxt   = r_tx >> 1;
          w_cnt_nxt  = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_rx    <= w_rx_nxt;
      r_tx    <= w_tx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign io.o_ready      = r_ready;
  assign io.o_dout       = r_dout;
  assign io.o_dout_valid = r_valid;

endmodule

// File: tb/tb_top_level.sv
// Testbench for top_level: table of {reset, input word, repeat count, expected final
// output} rows, each output also compared with a reference filter built from the
// triangular tap formula, plus hand-written handshake, clock-enable and reset sequences.
module tb_top_level;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b1;

  fir_if bus ();

  top_level #(
    .DATA_WIDTH (24),
    .FIR_DEPTH  (128)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (en),
    .io    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    bit          rst_before;
    logic [23:0] din;
    int          reps;
    logic [23:0] exp_last;
  } vec_t;

  vec_t vecs[$];

  longint hist [128];
  int     head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint coef(input int k);
    return longint'((k < 64) ? k + 1 : 128 - k) * 64'sd4034;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 128; i++) hist[i] = 0;
    head = 0;
  endfunction

  function automatic logic [23:0] model_step(input logic [23:0] x);
    longint acc;
    longint sh;
    hist[head] = longint'($signed(x));
    head = (head + 1) % 128;
    acc = 0;
    for (int k = 0; k < 128; k++) acc += hist[(head - 1 - k + 256) % 128] * coef(k);
    sh = acc >>> 23;
    if (sh > 64'sd8388607) return 24'h7FFFFF;
    if (sh < -64'sd8388608) return 24'h800000;
    return sh[23:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {29'd0, bus.o_ready, bus.o_dout, bus.o_dout_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.o_ready}, 32'd1);
    model_reset();
  endtask

  // rx_gap: bit index before which i_en is held low for 10 cycles (-1 for none)
  task automatic send_word(input logic [23:0] x, input int rx_gap);
    int cnt;
    cnt = 0;
    while (!bus.o_ready && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.o_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.i_din_valid = 1'b1;
    for (int b = 0; b < 24; b++) begin
      if (b == rx_gap) begin
        en = 1'b0;
        bus.i_din = ~x[b];
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
      bus.i_din = x[b];
      @(negedge clk);
      bus.i_din_valid = 1'b0;
    end
    bus.i_din = 1'b0;
  endtask

  // Called on the negedge right after the bit-23 edge.
  task automatic recv_word(input int tx_gap, input int rdy_delay, output logic [23:0] y);
    int cnt;
    int bad;
    cnt = 1;
    while (!bus.o_dout_valid && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    // valid rises 130 edges after the bit-23 edge, seen on the negedge after it
    check("valid_latency", cnt, 32'd131);
    bad = 0;
    repeat (rdy_delay) begin
      if (!bus.o_dout_valid || bus.o_ready) bad++;
      @(negedge clk);
    end
    if (rdy_delay > 0) check("hold_valid", bad, 32'd0);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == tx_gap) begin
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
      end
      @(negedge clk);
      y[k] = bus.o_dout;
      bus.i_ready = 1'b0;
    end
    @(negedge clk);
    check("tx_end", {30'd0, bus.o_dout, bus.o_dout_valid}, 32'd0);
  endtask

  task automatic do_sample(input logic [23:0] x, input int rx_gap, input int tx_gap,
                           input int rdy_delay, output logic [23:0] y);
    send_word(x, rx_gap);
    recv_word(tx_gap, rdy_delay, y);
  endtask

  task automatic run_rows(input int lo, input int hi);
    logic [23:0] y;
    logic [23:0] e;
    for (int r = lo; r <= hi; r++) begin
      if (vecs[r].rst_before) do_reset();
      y = '0;
      for (int i = 0; i < vecs[r].reps; i++) begin
        do_sample(vecs[r].din, -1, -1, 0, y);
        e = model_step(vecs[r].din);
        check(vecs[r].name, {8'd0, y}, {8'd0, e});
      end
      check({vecs[r].name, "_last"}, {8'd0, y}, {8'd0, vecs[r].exp_last});
    end
  endtask

  function automatic vec_t mk(input string n, input bit r, input logic [23:0] d,
                              input int c, input logic [23:0] e);
    vec_t v;
    v.name = n; v.rst_before = r; v.din = d; v.reps = c; v.exp_last = e;
    return v;
  endfunction

  initial begin
    logic [23:0] y;
    int bad;
    bus.i_din = 1'b0;
    bus.i_din_valid = 1'b0;
    bus.i_ready = 1'b0;
    model_reset();

    // Tap sum 16781440: 64 full-scale samples already cover half the gain (8390720).
    vecs.push_back(mk("sat_pos",  1'b1, 24'h7FFFFF, 64,  24'h7FFFFF));
    vecs.push_back(mk("sat_neg",  1'b1, 24'h800000, 64,  24'h800000));
    vecs.push_back(mk("dc_fill",  1'b1, 24'h100000, 128, 24'h200210));
    // 0x400000 * h[n] >>> 23 = h[n] / 2; h[0] = h[127] = 4034
    vecs.push_back(mk("imp_head", 1'b0, 24'h400000, 1,   24'h0007E1));
    vecs.push_back(mk("imp_tail", 1'b0, 24'h000000, 127, 24'h0007E1));
    vecs.push_back(mk("imp_zero", 1'b0, 24'h000000, 1,   24'h000000));

    do_reset();
    run_rows(0, 2);

    // Clock enable dropped mid-RX and mid-TX on a settled DC stream.
    do_sample(24'h100000, 9, 12, 0, y);
    check("dc_en_gap", {8'd0, y}, {8'd0, model_step(24'h100000)});
    check("dc_en_gap_const", {8'd0, y}, 32'h200210);

    // Sink withholds i_ready for 200 cycles.
    do_sample(24'h100000, -1, -1, 200, y);
    check("dc_ready_hold", {8'd0, y}, 32'h200210);
    void'(model_step(24'h100000));

    // Reset in the middle of the MAC pass: no output word may appear.
    send_word(24'h123456, -1);
    repeat (50) @(negedge clk);
    do_reset();
    bad = 0;
    repeat (200) begin
      if (bus.o_dout_valid) bad++;
      @(negedge clk);
    end
    check("no_valid_after_mac_rst", bad, 32'd0);

    // Impulse right after that reset must see an empty delay line.
    run_rows(3, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
